vga_frame_analyzer: RTL and testbench
=====================================

Name: vga_frame_analyzer

Overview:
- Sink-side counterpart of the VGA timing/draw path: receives an HS/VS/DE/RGB stream and measures H/V totals, active area and stability.
- Reconstructs pixel coordinates and captures the RGB value at a programmable probe coordinate.
- Sits on the VGA output of the tetris draw pipeline, in the bench loopback or in on-chip debug, to check resolution and pixel content without a monitor.

Parameters:
- PIX_WIDTH, 12, width of all coordinate and measurement counters.
- HS_POL, 0, active level of vga_hs_i (0 = active-low).
- VS_POL, 0, active level of vga_vs_i (0 = active-low).

Ports:
- clk_i  in  1  pixel clock.
- rst_i  in  1  reset; asynchronous, active-high.
- vga_hs_i  in  1  horizontal sync.
- vga_vs_i  in  1  vertical sync.
- vga_de_i  in  1  data enable.
- vga_rgb_i  in  24  pixel data {R,G,B}.
- probe_x_i  in  PIX_WIDTH  probe column.
- probe_y_i  in  PIX_WIDTH  probe row.
- pix_x_o  out  PIX_WIDTH  reconstructed column of the current registered pixel.
- pix_y_o  out  PIX_WIDTH  reconstructed row of the current registered pixel.
- h_total_o  out  PIX_WIDTH  clocks per line.
- h_disp_o  out  PIX_WIDTH  DE-high clocks in the first active line.
- v_total_o  out  PIX_WIDTH  lines per frame.
- v_disp_o  out  PIX_WIDTH  lines containing at least one DE cycle.
- meas_valid_o  out  1  one-cycle pulse when the measurement outputs update.
- line_err_o  out  1  the last measured frame had unequal active line widths.
- locked_o  out  1  two consecutive frames measured identical and error-free.
- probe_rgb_o  out  24  RGB captured at the probe coordinate.
- probe_hit_o  out  1  one-cycle pulse when the probe pixel is captured.

Behaviour:
Reset:
- All outputs and internal state reset to 0, including the started flag.
- Reset mid-frame discards all partial counts.
- After reset release, the first VS leading edge only arms the measurement. The first meas_valid_o comes at the second VS leading edge.

Input stage:
- HS, VS, DE and RGB are registered once (stage s1), then once more (s2) for edge detection.
- "Sync active" means s1 equals the corresponding *_POL.
- A leading edge is s1 active while s2 inactive.

Horizontal:
- h_cnt clears to 0 on the HS leading edge and increments on every other cycle.
- At each HS leading edge: line_len = h_cnt + 1.
- de_cnt counts s1 DE-high cycles within the line and clears on the DE rising edge.
- On the DE falling edge (s1 low, s2 high) the line is finished:
  - width = de_cnt.
  - The first active line of the frame sets frame_hdisp.
  - A later line with width != frame_hdisp sets frame_err.

Vertical:
- line_cnt increments on each HS leading edge.
- act_lines increments on each DE falling edge.
- On the VS leading edge, when started = 1:
  - h_total_o <= line_len of the most recent line.
  - h_disp_o <= frame_hdisp.
  - v_total_o <= line_cnt.
  - v_disp_o <= act_lines.
  - line_err_o <= frame_err.
  - meas_valid_o pulses in the same cycle as these register updates.
- Then line_cnt, act_lines, frame_err and frame_hdisp clear. If HS and VS leading edges coincide, the VS update uses the count before that HS increment, and line_cnt restarts at 0.

Lock:
- At each update, locked_o <= (new h_total, h_disp, v_total, v_disp equal the previous update's values) AND NOT frame_err.
- The first update after reset always leaves locked_o = 0.

Arithmetic:
- All counters saturate at 2^PIX_WIDTH-1 and never wrap. A saturated h_cnt or line_cnt sets frame_err, so a missing sync never yields lock.

Coordinates:
- pix_x_o is 0 on the first DE cycle of a line and increments per DE cycle. pix_y_o increments on each DE falling edge and clears on the VS leading edge.
- Both are aligned with s1 RGB.
- Latency from the pins to pix_x_o/pix_y_o is 1 cycle. Outside DE they hold their last values.

Probe:
- When s1 DE = 1 and pix_x == probe_x_i and pix_y == probe_y_i: probe_rgb_o <= s1 RGB and probe_hit_o pulses on the next cycle. Total latency from the pins is 2 cycles.
- Probe inputs may change at any time and take effect on the next compare.

Test Plan:
- Reduced timing: H = 8 disp / 2 fp / 3 sync / 3 bp, V = 4 / 1 / 2 / 2, both polarities active-low, 3 frames -> no meas_valid_o on frame 1. Updates at the 2nd and 3rd VS leading edges give h_total 16, h_disp 8, v_total 9, v_disp 4. locked_o is 0 after the 2nd, 1 after the 3rd. line_err_o = 0.
- Same stream with RGB = {y,x,8'hA5} (one byte each), probe (5,2) -> probe_hit_o once per frame, probe_rgb_o = 24'h0205A5, 2 cycles after that pixel is at the pins.
- DE of row 2 shortened to 7 in one frame -> that update gives line_err_o = 1 and locked_o = 0. The next clean frame gives line_err_o = 0, with locked_o = 1 at the update after that.
- HS_POL = 1 with inverted HS stimulus -> same values as the first scenario. Stimulus polarity mismatched to parameter -> h_total reports 16 still (edge on the other transition), with h_disp 8 unchanged.
- VS held inactive for 5000 clocks -> no meas_valid_o and no lock. On VS return the update gives line_err_o = 1, v_total saturated value 4095 or the true count, whichever is lower.
- rst_i asserted mid-frame for 1 cycle, asynchronously between edges -> all outputs 0 immediately. The first meas_valid_o comes at the 2nd subsequent VS leading edge with correct values.

Source files
------------

// File: rtl/vga_frame_analyzer.sv
// Sink-side VGA stream analyzer: measures line/frame timing, checks active-line
// consistency and lock, reconstructs pixel coordinates and samples a probe pixel.
module vga_frame_analyzer #(
  parameter int unsigned PIX_WIDTH = 12,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 vga_hs_i,
  input  logic                 vga_vs_i,
  input  logic                 vga_de_i,
  input  logic [23:0]          vga_rgb_i,
  input  logic [PIX_WIDTH-1:0] probe_x_i,
  input  logic [PIX_WIDTH-1:0] probe_y_i,
  output logic [PIX_WIDTH-1:0] pix_x_o,
  output logic [PIX_WIDTH-1:0] pix_y_o,
  output logic [PIX_WIDTH-1:0] h_total_o,
  output logic [PIX_WIDTH-1:0] h_disp_o,
  output logic [PIX_WIDTH-1:0] v_total_o,
  output logic [PIX_WIDTH-1:0] v_disp_o,
  output logic                 meas_valid_o,
  output logic                 line_err_o,
  output logic                 locked_o,
  output logic [23:0]          probe_rgb_o,
  output logic                 probe_hit_o
);

  localparam logic [PIX_WIDTH-1:0] MAX    = '1;
  localparam logic [PIX_WIDTH-1:0] MAX_M1 = MAX - 1'b1;

  function automatic logic [PIX_WIDTH-1:0] sat_inc(input logic [PIX_WIDTH-1:0] v);
    return (v == MAX) ? v : v + 1'b1;
  endfunction

  logic                 hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q;
  logic [23:0]          rgb1_q;
  logic [PIX_WIDTH-1:0] h_cnt_q, line_len_q, de_cnt_q, line_cnt_q, act_lines_q, frame_hdisp_q;
  logic                 frame_err_q, started_q, prev_ok_q;
  logic [PIX_WIDTH-1:0] h_total_q, h_disp_q, v_total_q, v_disp_q, pix_x_q, pix_y_q;
  logic                 meas_valid_q, line_err_q, locked_q, probe_hit_q;
  logic [23:0]          probe_rgb_q;

  logic                 hs_lead, vs_lead, de_rise, de_fall, pin_vs_lead, pin_de_fall;
  logic [PIX_WIDTH-1:0] line_len_d, h_total_d;
  logic                 frame_err_d, locked_d, probe_match;

  assign hs_lead     = (hs1_q == HS_POL) && (hs2_q != HS_POL);
  assign vs_lead     = (vs1_q == VS_POL) && (vs2_q != VS_POL);
  assign de_rise     = de1_q && !de2_q;
  assign de_fall     = !de1_q && de2_q;
  // Coordinates are derived one stage earlier (pins vs s1) so they line up with s1 RGB.
  assign pin_vs_lead = (vga_vs_i == VS_POL) && (vs1_q != VS_POL);
  assign pin_de_fall = !vga_de_i && de1_q;

  assign line_len_d  = sat_inc(h_cnt_q);
  assign h_total_d   = hs_lead ? line_len_d : line_len_q;

  // Saturation is flagged on the cycle a counter reaches its ceiling, so a stalled
  // sync marks only the frame in which it happened.
  assign frame_err_d = frame_err_q
                     || (!hs_lead && (h_cnt_q == MAX_M1))
                     || (hs_lead && (line_cnt_q == MAX_M1))
                     || (de_fall && (act_lines_q != '0) && (de_cnt_q != frame_hdisp_q));

  assign locked_d    = prev_ok_q && !frame_err_d
                     && (h_total_d == h_total_q) && (frame_hdisp_q == h_disp_q)
                     && (line_cnt_q == v_total_q) && (act_lines_q == v_disp_q);

  assign probe_match = de1_q && (pix_x_q == probe_x_i) && (pix_y_q == probe_y_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hs1_q <= 1'b0; vs1_q <= 1'b0; de1_q <= 1'b0;
      hs2_q <= 1'b0; vs2_q <= 1'b0; de2_q <= 1'b0;
      rgb1_q <= '0;
    end else begin
      hs1_q <= vga_hs_i; vs1_q <= vga_vs_i; de1_q <= vga_de_i;
      hs2_q <= hs1_q;    vs2_q <= vs1_q;    de2_q <= de1_q;
      rgb1_q <= vga_rgb_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0; line_len_q <= '0; de_cnt_q <= '0;
      line_cnt_q <= '0; act_lines_q <= '0; frame_hdisp_q <= '0;
      frame_err_q <= 1'b0; started_q <= 1'b0; prev_ok_q <= 1'b0;
      h_total_q <= '0; h_disp_q <= '0; v_total_q <= '0; v_disp_q <= '0;
      meas_valid_q <= 1'b0; line_err_q <= 1'b0; locked_q <= 1'b0;
    end else begin
      h_cnt_q <= hs_lead ? '0 : sat_inc(h_cnt_q);
      if (hs_lead) line_len_q <= line_len_d;
      if (de_rise) de_cnt_q <= PIX_WIDTH'(1);
      else if (de1_q) de_cnt_q <= sat_inc(de_cnt_q);
      meas_valid_q <= 1'b0;
      if (vs_lead) begin
        started_q <= 1'b1;
        if (started_q) begin
          h_total_q    <= h_total_d;
          h_disp_q     <= frame_hdisp_q;
          v_total_q    <= line_cnt_q;
          v_disp_q     <= act_lines_q;
          line_err_q   <= frame_err_d;
          locked_q     <= locked_d;
          prev_ok_q    <= !frame_err_d;
          meas_valid_q <= 1'b1;
        end
        line_cnt_q <= '0; act_lines_q <= '0; frame_hdisp_q <= '0; frame_err_q <= 1'b0;
      end else begin
        if (hs_lead) line_cnt_q <= sat_inc(line_cnt_q);
        if (de_fall) begin
          act_lines_q <= sat_inc(act_lines_q);
          if (act_lines_q == '0) frame_hdisp_q <= de_cnt_q;
        end
        frame_err_q <= frame_err_d;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_x_q <= '0; pix_y_q <= '0; probe_rgb_q <= '0; probe_hit_q <= 1'b0;
    end else begin
      if (vga_de_i) pix_x_q <= de1_q ? sat_inc(pix_x_q) : '0;
      if (pin_vs_lead) pix_y_q <= '0;
      else if (pin_de_fall) pix_y_q <= sat_inc(pix_y_q);
      probe_hit_q <= probe_match;
      if (probe_match) probe_rgb_q <= rgb1_q;
    end
  end

  assign pix_x_o      = pix_x_q;
  assign pix_y_o      = pix_y_q;
  assign h_total_o    = h_total_q;
  assign h_disp_o     = h_disp_q;
  assign v_total_o    = v_total_q;
  assign v_disp_o     = v_disp_q;
  assign meas_valid_o = meas_valid_q;
  assign line_err_o   = line_err_q;
  assign locked_o     = locked_q;
  assign probe_rgb_o  = probe_rgb_q;
  assign probe_hit_o  = probe_hit_q;

endmodule

// File: tb/tb_vga_frame_analyzer.sv
// Directed bench for vga_frame_analyzer: 16x9 reduced-timing frames with line
// error, sync stall, polarity variants, probe capture and mid-frame reset.
module tb_vga_frame_analyzer;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs, vs, de;
  logic [23:0] rgb;
  logic [11:0] px, py;

  logic [11:0] pix_x_o, pix_y_o, h_total_o, h_disp_o, v_total_o, v_disp_o;
  logic        meas_valid_o, line_err_o, locked_o, probe_hit_o;
  logic [23:0] probe_rgb_o;

  logic [11:0] p_pix_x, p_pix_y, p_ht, p_hd, p_vt, p_vd;
  logic        p_mv, p_err, p_lock, p_hit;
  logic [23:0] p_rgb;
  logic [11:0] q_pix_x, q_pix_y, q_ht, q_hd, q_vt, q_vd;
  logic        q_mv, q_err, q_lock, q_hit;
  logic [23:0] q_rgb;

  int          vecs = 0;
  int          errs = 0;
  int          meas_cnt, hit_cnt;
  logic [11:0] m_ht, m_hd, m_vt, m_vd;
  logic        m_err, m_lock;

  always #5 clk = ~clk;

  vga_frame_analyzer #(.PIX_WIDTH(12), .HS_POL(1'b0), .VS_POL(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst), .vga_hs_i(hs), .vga_vs_i(vs), .vga_de_i(de), .vga_rgb_i(rgb),
    .probe_x_i(px), .probe_y_i(py), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
    .h_total_o(h_total_o), .h_disp_o(h_disp_o), .v_total_o(v_total_o), .v_disp_o(v_disp_o),
    .meas_valid_o(meas_valid_o), .line_err_o(line_err_o), .locked_o(locked_o),
    .probe_rgb_o(probe_rgb_o), .probe_hit_o(probe_hit_o));

  // Positive-HS instance fed inverted HS: should measure identically.
  vga_frame_analyzer #(.PIX_WIDTH(12), .HS_POL(1'b1), .VS_POL(1'b0)) u_pol (
    .clk_i(clk), .rst_i(rst), .vga_hs_i(~hs), .vga_vs_i(vs), .vga_de_i(de), .vga_rgb_i(rgb),
    .probe_x_i(px), .probe_y_i(py), .pix_x_o(p_pix_x), .pix_y_o(p_pix_y),
    .h_total_o(p_ht), .h_disp_o(p_hd), .v_total_o(p_vt), .v_disp_o(p_vd),
    .meas_valid_o(p_mv), .line_err_o(p_err), .locked_o(p_lock),
    .probe_rgb_o(p_rgb), .probe_hit_o(p_hit));

  // Positive-HS instance fed active-low HS: locks on the trailing transition instead.
  vga_frame_analyzer #(.PIX_WIDTH(12), .HS_POL(1'b1), .VS_POL(1'b0)) u_mis (
    .clk_i(clk), .rst_i(rst), .vga_hs_i(hs), .vga_vs_i(vs), .vga_de_i(de), .vga_rgb_i(rgb),
    .probe_x_i(px), .probe_y_i(py), .pix_x_o(q_pix_x), .pix_y_o(q_pix_y),
    .h_total_o(q_ht), .h_disp_o(q_hd), .v_total_o(q_vt), .v_disp_o(q_vd),
    .meas_valid_o(q_mv), .line_err_o(q_err), .locked_o(q_lock),
    .probe_rgb_o(q_rgb), .probe_hit_o(q_hit));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic h, input logic v, input logic d, input logic [23:0] c);
    hs = h; vs = v; de = d; rgb = c;
    @(posedge clk);
    #1;
    if (meas_valid_o) begin
      meas_cnt++;
      m_ht = h_total_o; m_hd = h_disp_o; m_vt = v_total_o; m_vd = v_disp_o;
      m_err = line_err_o; m_lock = locked_o;
    end
    if (probe_hit_o) hit_cnt++;
  endtask

  // Line: x 0-7 display, 8-9 fp, 10-12 sync, 13-15 bp. Frame: rows 0-3, 4 fp, 5-6 sync, 7-8 bp.
  task automatic run_frame(input int short_row, input int rst_line);
    meas_cnt = 0;
    hit_cnt  = 0;
    for (int line = 0; line < 9; line++) begin
      for (int x = 0; x < 16; x++) begin
        if (line == rst_line && x == 3) begin
          #2 rst = 1'b1;
          #1 chk("async_reset_outputs",
                 {pix_x_o, pix_y_o, h_total_o, h_disp_o, v_total_o, v_disp_o,
                  meas_valid_o, line_err_o, locked_o, probe_rgb_o, probe_hit_o}, '0);
        end
        step(!(x >= 10 && x <= 12), !(line == 5 || line == 6),
             (line < 4) && (x < ((line == short_row) ? 7 : 8)),
             {8'(line), 8'(x), 8'hA5});
        if (rst) #1 rst = 1'b0;
        if (line == 2 && x == 5) chk("pix_xy_at_5_2", {pix_x_o, pix_y_o}, {12'd5, 12'd2});
        if (line == 2 && x == 6) begin
          chk("probe_hit_latency", probe_hit_o, 1'b1);
          chk("probe_rgb", probe_rgb_o, 24'h0205A5);
        end
      end
    end
    chk("probe_hits_per_frame", hit_cnt, 1);
  endtask

  task automatic chk_meas(input string tag, input logic err, input logic lock);
    chk({tag, "_meas_cnt"}, meas_cnt, 1);
    chk({tag, "_totals"}, {m_ht, m_hd, m_vt, m_vd}, {12'd16, 12'd8, 12'd9, 12'd4});
    chk({tag, "_err_lock"}, {m_err, m_lock}, {err, lock});
  endtask

  initial begin
    rst = 1'b1; hs = 1'b1; vs = 1'b1; de = 1'b0; rgb = '0;
    px = 12'd5; py = 12'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {pix_x_o, pix_y_o, h_total_o, h_disp_o, v_total_o, v_disp_o,
         meas_valid_o, line_err_o, locked_o, probe_rgb_o, probe_hit_o}, '0);
    rst = 1'b0;

    run_frame(-1, -1);
    chk("f1_no_meas", meas_cnt, 0);
    run_frame(-1, -1);
    chk_meas("f2", 1'b0, 1'b0);
    run_frame(-1, -1);
    chk_meas("f3", 1'b0, 1'b1);
    chk("pol_inverted_hs", {p_ht, p_hd, p_vt, p_vd, p_err, p_lock},
        {12'd16, 12'd8, 12'd9, 12'd4, 1'b0, 1'b1});
    chk("pol_mismatched_hs", {q_ht, q_hd}, {12'd16, 12'd8});

    run_frame(2, -1);
    chk_meas("f4_short_row", 1'b1, 1'b0);
    run_frame(-1, -1);
    chk_meas("f5_recover", 1'b0, 1'b0);
    run_frame(-1, -1);
    chk_meas("f6_relock", 1'b0, 1'b1);

    meas_cnt = 0;
    repeat (5000) step(1'b1, 1'b1, 1'b0, 24'h0);
    chk("stall_no_meas", meas_cnt, 0);
    run_frame(-1, -1);
    chk_meas("f7_after_stall", 1'b1, 1'b0);
    run_frame(-1, -1);
    chk_meas("f8", 1'b0, 1'b0);
    run_frame(-1, -1);
    chk_meas("f9", 1'b0, 1'b1);

    run_frame(-1, 6);
    run_frame(-1, -1);
    chk("post_reset_arm_no_meas", meas_cnt, 0);
    run_frame(-1, -1);
    chk_meas("post_reset_first", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
